// File: rtl/phase_pkg.sv
// Shared types and constants for the phase shadow bank (optional calibration: PHASE_CALIB_EN).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package phase_pkg;

    localparam int PHASE_W_DEF      = 8;
    localparam int NUM_CHANNELS_DEF = 256;

    // Field offsets inside latest_data
    localparam int ADDR_LSB = 0;
    localparam int VAL_LSB  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        COMMIT = 2'd2
    } shadow_state_t;

    // Host command codes decoded upstream by the command receiver
    localparam logic [15:0] CMD_SET_PHASE   = 16'h0001;
    localparam logic [15:0] CMD_SET_CALIB   = 16'h0002;
    localparam logic [15:0] CMD_OUT_ENABLE  = 16'h0003;
    localparam logic [15:0] CMD_OUT_DISABLE = 16'h0004;

endpackage

// File: rtl/phase_chan_slot.sv
// One channel: shadow word, optional calib word (PHASE_CALIB_EN), active word and output register.
// Latency: commit strobe -> phase_out two edges later (active load, then output register).
// Backpressure: none; writes are always accepted.
module phase_chan_slot
    import phase_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               shadow_we,
    input  logic               calib_we,
    input  logic               commit,
    input  logic [PHASE_W-1:0] wr_val,
    output logic [PHASE_W-1:0] phase_out
);

    logic [PHASE_W-1:0] shadow_q;
    logic [PHASE_W-1:0] active_q;
    logic [PHASE_W-1:0] commit_val;

`ifdef PHASE_CALIB_EN
    logic [PHASE_W-1:0] calib_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            calib_q <= '0;
        else if (calib_we)
            calib_q <= wr_val;
    end

    // Natural PHASE_W-bit wrap gives the modulo sum
    assign commit_val = shadow_q + calib_q;
`else
    logic unused_calib_we;
    assign unused_calib_we = calib_we;
    assign commit_val      = shadow_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            active_q  <= '0;
            phase_out <= '0;
        end else begin
            if (shadow_we)
                shadow_q <= wr_val;
            if (commit)
                active_q <= commit_val;
            // Registered output keeps the phase generators free of adder glitches
            phase_out <= active_q;
        end
    end

endmodule

// File: rtl/phase_shadow_bank.sv
// Shadow/active phase bank committed on period_sync; calibration offsets when PHASE_CALIB_EN is defined.
// Latency: period_sync sampled in ARMED at edge s -> phases_out/outputs_en updated after edge s+2.
// Backpressure: none; out-of-range writes are dropped and flagged on sticky addr_error.
module phase_shadow_bank
    import phase_pkg::*;
#(
    parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
    parameter int PHASE_W      = PHASE_W_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            phase_parse_en,
    input  logic                            phase_calib_en,
    input  logic                            global_enable,
    input  logic [31:0]                     latest_data,
    input  logic                            period_sync,
    output logic [NUM_CHANNELS*PHASE_W-1:0] phases_out,
    output logic                            outputs_en,
    output logic                            update_pending,
    output logic                            addr_error
);

    shadow_state_t state_q, state_d;

    logic [7:0]         addr;
    logic [PHASE_W-1:0] wr_val;
    logic               addr_ok;
    logic               parse_ok;
    logic               calib_ok;
    logic               bad_addr;
    logic               wr_acc;
    logic               commit;
    logic               en_commit_q;

    logic unused_data;
    assign unused_data = ^latest_data[31:16];

    assign addr    = latest_data[ADDR_LSB +: 8];
    assign wr_val  = PHASE_W'(latest_data[VAL_LSB +: 8]);
    assign addr_ok = (32'(addr) < 32'(NUM_CHANNELS));

    assign parse_ok = phase_parse_en && addr_ok;
`ifdef PHASE_CALIB_EN
    assign calib_ok = phase_calib_en && addr_ok;
    assign bad_addr = (phase_parse_en || phase_calib_en) && !addr_ok;
`else
    logic unused_calib_en;
    assign unused_calib_en = phase_calib_en;
    assign calib_ok        = 1'b0;
    assign bad_addr        = phase_parse_en && !addr_ok;
`endif
    assign wr_acc = parse_ok || calib_ok;
    assign commit = (state_q == COMMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            // Compare against the committed enable, not the delayed output copy
            IDLE:    if (wr_acc || (global_enable != en_commit_q)) state_d = ARMED;
            ARMED:   if (period_sync) state_d = COMMIT;
            COMMIT:  state_d = wr_acc ? ARMED : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_commit_q <= 1'b1;
            outputs_en  <= 1'b1;
            addr_error  <= 1'b0;
        end else begin
            if (commit)
                en_commit_q <= global_enable;
            outputs_en <= en_commit_q;
            if (bad_addr)
                addr_error <= 1'b1;
        end
    end

    assign update_pending = (state_q != IDLE);

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        logic hit;
        assign hit = (addr == 8'(i));

        phase_chan_slot #(
            .PHASE_W (PHASE_W)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .shadow_we (parse_ok && hit),
            .calib_we  (calib_ok && hit),
            .commit    (commit),
            .wr_val    (wr_val),
            .phase_out (phases_out[i*PHASE_W +: PHASE_W])
        );
    end

endmodule

// File: tb/tb_phase_shadow_bank.sv
// Directed bench for phase_shadow_bank: a 256-channel and a 64-channel instance share one stimulus stream.
module tb_phase_shadow_bank;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          phase_parse_en;
    logic          phase_calib_en;
    logic          global_enable;
    logic [31:0]   latest_data;
    logic          period_sync;

    logic [2047:0] phases_out;
    logic          outputs_en;
    logic          update_pending;
    logic          addr_error;

    logic [511:0]  phases_out_64;
    logic          outputs_en_64;
    logic          update_pending_64;
    logic          addr_error_64;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    phase_shadow_bank #(.NUM_CHANNELS(256), .PHASE_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .phase_parse_en (phase_parse_en),
        .phase_calib_en (phase_calib_en),
        .global_enable  (global_enable),
        .latest_data    (latest_data),
        .period_sync    (period_sync),
        .phases_out     (phases_out),
        .outputs_en     (outputs_en),
        .update_pending (update_pending),
        .addr_error     (addr_error)
    );

    phase_shadow_bank #(.NUM_CHANNELS(64), .PHASE_W(8)) dut64 (
        .clk            (clk),
        .rst_n          (rst_n),
        .phase_parse_en (phase_parse_en),
        .phase_calib_en (phase_calib_en),
        .global_enable  (global_enable),
        .latest_data    (latest_data),
        .period_sync    (period_sync),
        .phases_out     (phases_out_64),
        .outputs_en     (outputs_en_64),
        .update_pending (update_pending_64),
        .addr_error     (addr_error_64)
    );

    function automatic logic [7:0] ch(input int i);
        return phases_out[i*8 +: 8];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic phase_wr(input logic [7:0] a, input logic [7:0] v);
        latest_data    = {16'h0000, v, a};
        phase_parse_en = 1'b1;
        tick();
        phase_parse_en = 1'b0;
    endtask

    // Pulse sync for one edge (s), then advance to just after edge s+2
    task automatic sync_commit();
        period_sync = 1'b1;
        tick();
        period_sync = 1'b0;
        tick(2);
    endtask

    initial begin
        rst_n          = 1'b0;
        phase_parse_en = 1'b0;
        phase_calib_en = 1'b0;
        global_enable  = 1'b1;
        latest_data    = 32'h0;
        period_sync    = 1'b0;
        tick(3);
        check("rst_phases_any", {31'b0, |phases_out}, 32'h0);
        check("rst_outputs_en", {31'b0, outputs_en}, 32'h1);
        check("rst_pending", {31'b0, update_pending}, 32'h0);
        check("rst_addr_error", {31'b0, addr_error}, 32'h0);
        rst_n = 1'b1;
        tick(2);

        // Shadow write held until period_sync
        phase_wr(8'd5, 8'h40);
        check("t2_pending_after_wr", {31'b0, update_pending}, 32'h1);
        tick(100);
        check("t2_ch5_held", {24'b0, ch(5)}, 32'h00);
        check("t2_pending_held", {31'b0, update_pending}, 32'h1);
        period_sync = 1'b1;
        tick();
        period_sync = 1'b0;
        check("t2_ch5_after_s", {24'b0, ch(5)}, 32'h00);
        tick();
        check("t2_ch5_after_s1", {24'b0, ch(5)}, 32'h00);
        tick();
        check("t2_ch5_after_s2", {24'b0, ch(5)}, 32'h40);
        check("t2_pending_clear", {31'b0, update_pending}, 32'h0);
        period_sync = 1'b1;
        tick();
        period_sync = 1'b0;
        tick(3);
        check("t2_sync_idle_ignored", {31'b0, update_pending}, 32'h0);

        // Calibration offset with modular wrap
        latest_data    = 32'h0000_F005;
        phase_calib_en = 1'b1;
        tick();
        phase_calib_en = 1'b0;
`ifdef PHASE_CALIB_EN
        check("t3_pending_calib", {31'b0, update_pending}, 32'h1);
`else
        check("t3_pending_calib", {31'b0, update_pending}, 32'h0);
`endif
        check("t3_calib_no_err", {31'b0, addr_error}, 32'h0);
        phase_wr(8'd5, 8'h20);
        sync_commit();
`ifdef PHASE_CALIB_EN
        check("t3_ch5_wrap", {24'b0, ch(5)}, 32'h10);
`else
        check("t3_ch5_nocal", {24'b0, ch(5)}, 32'h20);
`endif

        // Write with sync included; write during COMMIT deferred
        phase_wr(8'd7, 8'h77);
        latest_data    = 32'h0000_1101;
        phase_parse_en = 1'b1;
        period_sync    = 1'b1;
        tick();
        period_sync    = 1'b0;
        latest_data    = 32'h0000_2202;
        tick();
        phase_parse_en = 1'b0;
        tick();
        check("t5_ch1_included", {24'b0, ch(1)}, 32'h11);
        check("t5_ch7_included", {24'b0, ch(7)}, 32'h77);
        check("t5_ch2_deferred", {24'b0, ch(2)}, 32'h00);
        check("t5_pending_between", {31'b0, update_pending}, 32'h1);
        tick(10);
        check("t5_ch2_still_old", {24'b0, ch(2)}, 32'h00);
        check("t5_pending_still", {31'b0, update_pending}, 32'h1);
        sync_commit();
        check("t5_ch2_applied", {24'b0, ch(2)}, 32'h22);
        check("t5_pending_done", {31'b0, update_pending}, 32'h0);

        // Last write before the commit wins
        phase_wr(8'd9, 8'h12);
        phase_wr(8'd9, 8'h99);
        sync_commit();
        check("lastwins_ch9", {24'b0, ch(9)}, 32'h99);

        // Address range: 0x80 legal for 256 channels, dropped for 64
        check("t4_err64_before", {31'b0, addr_error_64}, 32'h0);
        phase_wr(8'h80, 8'h5A);
        check("t4_err64_set", {31'b0, addr_error_64}, 32'h1);
        check("t4_pending64", {31'b0, update_pending_64}, 32'h0);
        check("t4_err256_clear", {31'b0, addr_error}, 32'h0);
        check("t4_pending256", {31'b0, update_pending}, 32'h1);
        sync_commit();
        check("t4_ch128", {24'b0, ch(128)}, 32'h5A);
        check("t4_ch0_64_untouched", {24'b0, phases_out_64[7:0]}, 32'h00);
        check("t4_err64_sticky", {31'b0, addr_error_64}, 32'h1);
        latest_data    = 32'h0000_01FF;
        phase_parse_en = 1'b1;
        tick();
        phase_parse_en = 1'b0;
        check("t4_1ff_no_err", {31'b0, addr_error}, 32'h0);
        sync_commit();
        check("t4_ch255", {24'b0, ch(255)}, 32'h01);
        check("t4_err64_still", {31'b0, addr_error_64}, 32'h1);

        // Asynchronous reset away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_phases_any", {31'b0, |phases_out}, 32'h0);
        check("t1_outputs_en", {31'b0, outputs_en}, 32'h1);
        check("t1_pending", {31'b0, update_pending}, 32'h0);
        check("t1_addr_error", {31'b0, addr_error}, 32'h0);
        check("t1_addr_error_64", {31'b0, addr_error_64}, 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Enable change re-timed to the commit boundary
        global_enable = 1'b0;
        tick();
        check("t6_pending_en", {31'b0, update_pending}, 32'h1);
        check("t6_en_held", {31'b0, outputs_en}, 32'h1);
        tick(20);
        check("t6_en_held_long", {31'b0, outputs_en}, 32'h1);
        period_sync = 1'b1;
        tick();
        period_sync = 1'b0;
        tick();
        check("t6_en_after_s1", {31'b0, outputs_en}, 32'h1);
        tick();
        check("t6_en_after_s2", {31'b0, outputs_en}, 32'h0);
        tick(3);
        check("t6_no_rearm", {31'b0, update_pending}, 32'h0);

        // 128-channel burst committed by one sync
        for (int i = 0; i < 128; i++)
            phase_wr(8'(i), 8'((i * 3 + 1) & 8'hFF));
        period_sync = 1'b1;
        tick();
        period_sync = 1'b0;
        tick();
        check("t6_burst_not_yet", {24'b0, ch(127)}, 32'h00);
        tick();
        for (int i = 0; i < 128; i++)
            check($sformatf("t6_burst_ch%0d", i), {24'b0, ch(i)}, 32'((i * 3 + 1) & 255));
        check("t6_burst_pending", {31'b0, update_pending}, 32'h0);
        check("t6_ch128_reset", {24'b0, ch(128)}, 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
